roe_seq_ctrl: RTL and testbench

Program sequencer for the R.O.E. core. It accepts a start request, steps the PC through instruction memory with a fetch/execute/memory-wait/writeback FSM until a halt instruction decodes, then raises ack. It sits between the top-level req/ack handshake and the datapath: regfile write enable, IR load and data-memory request. A watchdog aborts runaway programs.

---
 rtl/roe_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_roe_seq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roe_seq_ctrl.sv
// roe_seq_ctrl: program sequencer for the R.O.E. core.
//
// Takes a start request and walks the PC through instruction memory. Each instruction goes
// through fetch, execute, an optional memory wait, and writeback. When a halt instruction
// decodes, the sequencer raises ack. A watchdog aborts programs that run too long.
//
// Ports:
//   clk, reset      rising-edge clock; asynchronous active-low reset
//   req / ack       start request (sampled in idle) / completion level
//   busy            high whenever the sequencer is not idle
//   pc, instr_i     instruction memory address / combinational read data
//   ir              latched instruction presented to the decoder
//   halt_i          decoder flag: ir is a halt
//   mem_op_i        decoder flag: ir is a load or store
//   mem_ready_i     data memory completion
//   branch_*        branch condition and destination from the datapath
//   ir_we           IR load strobe
//   rf_we           register file write strobe
//   mem_req         data memory request strobe
//   timeout         last run was aborted by the watchdog
//   cycle_count     active cycles of the current or last run
module roe_seq_ctrl #(
  parameter int unsigned     PC_W       = 10,
  parameter int unsigned     INSTR_W    = 9,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int unsigned     MAX_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  output logic               ack,
  output logic               busy,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [INSTR_W-1:0] ir,
  input  logic               halt_i,
  input  logic               mem_op_i,
  input  logic               mem_ready_i,
  input  logic               branch_taken_i,
  input  logic [PC_W-1:0]    branch_target_i,
  output logic               ir_we,
  output logic               rf_we,
  output logic               mem_req,
  output logic               timeout,
  output logic [15:0]        cycle_count
);

  localparam logic [15:0] WdLast = 16'(MAX_CYCLES - 1);
  localparam logic [15:0] CntMax = 16'(MAX_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMemWait,
    StWb,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q;
  logic [INSTR_W-1:0]   ir_q;
  logic                 ack_q;
  logic                 timeout_q;
  logic [15:0]          cnt_q;
  logic                 wd_active;
  logic                 wd_fire;

  // The watchdog only watches the instruction-processing states.
  assign wd_active = (state_q == StFetch) || (state_q == StExec) ||
                     (state_q == StMemWait) || (state_q == StWb);
  assign wd_fire   = wd_active && (cnt_q == WdLast);

  always_comb begin
    state_d = state_q;
    ir_we   = 1'b0;
    rf_we   = 1'b0;
    mem_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) state_d = StFetch;
      end
      StFetch: begin
        ir_we   = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        if (halt_i) begin
          state_d = StDone;
        end else if (mem_op_i) begin
          mem_req = 1'b1;
          state_d = StMemWait;
        end else begin
          state_d = StWb;
        end
      end
      StMemWait: begin
        // The request is withdrawn on the cycle the watchdog kills the access.
        mem_req = ~wd_fire;
        if (mem_ready_i) state_d = StWb;
      end
      StWb: begin
        rf_we   = 1'b1;
        state_d = StFetch;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (wd_fire) state_d = StDone;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pc_q      <= START_ADDR;
      ir_q      <= '0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        if (req) begin
          pc_q      <= START_ADDR;
          ack_q     <= 1'b0;
          timeout_q <= 1'b0;
          cnt_q     <= '0;
        end
      end else if (cnt_q != CntMax) begin
        // Saturate at the limit so an aborted run reports exactly MAX_CYCLES.
        cnt_q <= cnt_q + 16'd1;
      end
      if (ir_we) ir_q <= instr_i;
      if ((state_q == StWb) && !wd_fire) begin
        pc_q <= branch_taken_i ? branch_target_i : pc_q + 1'b1;
      end
      if (wd_fire) timeout_q <= 1'b1;
      if (state_q == StDone) ack_q <= 1'b1;
    end
  end

  assign ack         = ack_q;
  assign busy        = (state_q != StIdle);
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_roe_seq_ctrl.sv
// Self-checking bench for roe_seq_ctrl. The bench holds the instruction memory and a toy
// decoder in which ir[8:7] is the opcode: 0 = ALU, 1 = memory, 2 = branch, 3 = halt. Each run
// is predicted at instruction granularity. The prediction covers the cycles used, the strobe
// counts, the final pc and the timeout flag. The DUT is then checked against it.
module tb_roe_seq_ctrl;

  localparam int         MaxCyc = 20;
  localparam logic [9:0] Start  = 10'd0;
  localparam logic [1:0] OpAlu  = 2'd0;
  localparam logic [1:0] OpMem  = 2'd1;
  localparam logic [1:0] OpBr   = 2'd2;
  localparam logic [1:0] OpHalt = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        ack, busy;
  logic [9:0]  pc;
  logic [8:0]  instr_i, ir;
  logic        halt_i, mem_op_i, mem_ready_i, branch_taken_i;
  logic [9:0]  branch_target_i;
  logic        ir_we, rf_we, mem_req, timeout;
  logic [15:0] cycle_count;

  logic [8:0]  rom [1024];
  bit          tk  [1024];
  logic [9:0]  tg  [1024];

  int total = 0;
  int bad = 0;
  int mem_lat = 1;
  int req_run = 0;
  int rf_cnt = 0, mr_cnt = 0, both_cnt = 0, fc1_cnt = 0, wrap_cnt = 0;
  logic [9:0] last_fetch = 10'd0;

  int         m_c, m_rf, m_mr;
  bit         m_to;
  logic [9:0] m_pc;

  always #5 clk = ~clk;

  assign instr_i         = rom[pc];
  assign halt_i          = (ir[8:7] == OpHalt);
  assign mem_op_i        = (ir[8:7] == OpMem);
  assign branch_taken_i  = (ir[8:7] == OpBr) && tk[pc];
  assign branch_target_i = tg[pc];
  assign mem_ready_i     = (req_run >= mem_lat);

  always @(posedge clk) req_run <= mem_req ? req_run + 1 : 0;

  always @(negedge clk) begin
    rf_cnt += int'(rf_we);
    mr_cnt += int'(mem_req);
    if (ack && busy) both_cnt++;
    if (ir_we) begin
      if (pc == 10'd1) fc1_cnt++;
      if (last_fetch == 10'd1023 && pc == 10'd0) wrap_cnt++;
      last_fetch = pc;
    end
  end

  roe_seq_ctrl #(
    .PC_W       (10),
    .INSTR_W    (9),
    .START_ADDR (Start),
    .MAX_CYCLES (MaxCyc)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .ack             (ack),
    .busy            (busy),
    .pc              (pc),
    .instr_i         (instr_i),
    .ir              (ir),
    .halt_i          (halt_i),
    .mem_op_i        (mem_op_i),
    .mem_ready_i     (mem_ready_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .ir_we           (ir_we),
    .rf_we           (rf_we),
    .mem_req         (mem_req),
    .timeout         (timeout),
    .cycle_count     (cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One active cycle ends at a clock edge; the watchdog fires on the edge seen at count MAX-1.
  function automatic bit tick();
    if (m_c == MaxCyc - 1) begin
      m_c  = MaxCyc;
      m_to = 1'b1;
      return 1'b1;
    end
    m_c++;
    return 1'b0;
  endfunction

  task automatic model();
    logic [1:0] op;
    bit ab;
    bit fin;
    m_pc = Start;
    m_c  = 0;
    m_rf = 0;
    m_mr = 0;
    m_to = 1'b0;
    fin  = 1'b0;
    for (int n = 0; n < 200 && !fin && !m_to; n++) begin
      op = rom[m_pc][8:7];
      if (tick()) break;
      if (op == OpMem) m_mr++;
      if (tick()) break;
      if (op == OpHalt) begin
        m_c++;
        fin = 1'b1;
        break;
      end
      if (op == OpMem) begin
        ab = 1'b0;
        for (int k = 0; k < mem_lat; k++) begin
          if (tick()) begin
            ab = 1'b1;
            break;
          end
          m_mr++;
        end
        if (ab) break;
      end
      m_rf++;
      if (tick()) break;
      m_pc = (op == OpBr && tk[m_pc]) ? tg[m_pc] : m_pc + 10'd1;
    end
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 1024; a++) begin
      rom[a] = {OpHalt, 7'h00};
      tk[a]  = 1'b0;
      tg[a]  = 10'd0;
    end
  endtask

  task automatic rand_rom();
    int r;
    logic [1:0] op;
    for (int a = 0; a < 1024; a++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? OpAlu : (r < 6) ? OpMem : (r < 8) ? OpBr : OpHalt;
      rom[a] = {op, 7'($urandom)};
      tk[a]  = 1'($urandom_range(0, 1));
      tg[a]  = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic do_run(input string nm, input int hold, output int o_rf, output int o_mr,
                        output int o_edges);
    int rf0, mr0;
    bit got;
    model();
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    rf0 = rf_cnt;
    mr0 = mr_cnt;
    check({nm, "_acc_ack"}, ack, 0);
    check({nm, "_acc_busy"}, busy, 1);
    check({nm, "_acc_timeout"}, timeout, 0);
    check({nm, "_acc_cc"}, cycle_count, 0);
    check({nm, "_acc_pc"}, pc, Start);
    o_edges = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (i == hold) req = 1'b0;
      @(posedge clk);
      o_edges++;
      #1;
      if (ack) got = 1'b1;
    end
    req  = 1'b0;
    o_rf = rf_cnt - rf0;
    o_mr = mr_cnt - mr0;
    check({nm, "_ack"}, got, 1);
    check({nm, "_edges"}, o_edges, m_to ? MaxCyc + 1 : m_c);
    check({nm, "_cc"}, cycle_count, m_c);
    check({nm, "_timeout"}, timeout, m_to);
    check({nm, "_pc"}, pc, m_pc);
    check({nm, "_rfwe"}, o_rf, m_rf);
    check({nm, "_memreq"}, o_mr, m_mr);
    check({nm, "_busy"}, busy, 0);
    if (!m_to) check({nm, "_ir"}, ir, rom[m_pc]);
  endtask

  initial begin
    int o_rf, o_mr, o_edges, f0, w0;
    clear_rom();
    #12;
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_pc", pc, Start);
    check("rst_ir", ir, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cc", cycle_count, 0);
    check("rst_strobes", {ir_we, rf_we, mem_req}, 0);
    @(negedge clk);
    reset = 1'b1;

    // ALU then halt, checked cycle by cycle from the accepting edge.
    rom[0] = {OpAlu, 7'h12};
    rom[1] = {OpHalt, 7'h00};
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check("alu_rfwe", rf_we, (k == 2) ? 1 : 0);
      check("alu_ack", ack, (k == 6) ? 1 : 0);
      if (k == 3) check("alu_pc", pc, 1);
    end
    check("alu_cc", cycle_count, 6);
    check("alu_timeout", timeout, 0);

    // Asynchronous reset in the middle of writeback.
    rom[0] = {OpAlu, 7'h55};
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_wb_rfwe", rf_we, 1);
    #1;
    reset = 1'b0;
    #1;
    check("arst_rfwe", rf_we, 0);
    check("arst_busy", busy, 0);
    check("arst_ack", ack, 0);
    check("arst_pc", pc, Start);
    check("arst_ir", ir, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("arst_noack", ack, 0);
    check("arst_idle", busy, 0);

    // Load with three wait cycles, then halt.
    clear_rom();
    rom[0] = {OpMem, 7'h21};
    mem_lat = 3;
    do_run("mem", 0, o_rf, o_mr, o_edges);
    check("mem_memreq4", o_mr, 4);
    check("mem_rfwe1", o_rf, 1);
    check("mem_edges9", o_edges, 9);
    check("mem_cc9", cycle_count, 9);

    // Ready already high on the first wait cycle.
    mem_lat = 1;
    do_run("mem_fast", 1, o_rf, o_mr, o_edges);
    check("mem_fast_cc", cycle_count, 7);

    // Taken branch to 5 skips address 1.
    clear_rom();
    rom[0] = {OpBr, 7'h00};
    tk[0]  = 1'b1;
    tg[0]  = 10'd5;
    rom[1] = {OpAlu, 7'h01};
    f0 = fc1_cnt;
    do_run("br", 2, o_rf, o_mr, o_edges);
    check("br_pc5", pc, 5);
    check("br_no_fetch1", fc1_cnt - f0, 0);

    // Tight infinite loop tripped by the watchdog.
    clear_rom();
    rom[0] = {OpBr, 7'h00};
    tk[0]  = 1'b1;
    tg[0]  = 10'd0;
    do_run("wd", 0, o_rf, o_mr, o_edges);
    check("wd_timeout", timeout, 1);
    check("wd_ack", ack, 1);
    check("wd_cc", cycle_count, MaxCyc);
    rom[0] = {OpHalt, 7'h00};
    do_run("after_wd", 2, o_rf, o_mr, o_edges);

    // PC walks 1022 -> 1023 -> 0.
    clear_rom();
    rom[0]    = {OpBr, 7'h00};
    tk[0]     = 1'b1;
    tg[0]     = 10'd1022;
    rom[1022] = {OpAlu, 7'h0a};
    rom[1023] = {OpAlu, 7'h0b};
    w0 = wrap_cnt;
    do_run("wrap", 0, o_rf, o_mr, o_edges);
    check("wrap_seen", (wrap_cnt > w0) ? 1 : 0, 1);

    for (int r = 0; r < 25; r++) begin
      rand_rom();
      mem_lat = $urandom_range(1, 4);
      do_run("rnd", $urandom_range(0, 2), o_rf, o_mr, o_edges);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check("rnd_ack_held", ack, 1);
    end

    check("ack_busy_excl", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
